// File: rtl/alu_op_issue.sv
// ID/EX issue register: decodes a MIPS instruction plus rs/rt read data into ALU op/operands.
// Optional saturating illegal-instruction counter enabled by ALU_OP_ISSUE_ILLEGAL_CNT_EN.
module alu_op_issue #(
  parameter int NB_DATA      = 32,
  parameter int NB_OPERATION = 4,
  parameter int NB_REG_ADDR  = 5,
  parameter int NB_ILL_CNT   = 8
) (
  input  logic                    i_clock,
  input  logic                    i_reset,
  input  logic                    i_valid,
  input  logic [31:0]             i_instruction,
  input  logic [NB_DATA-1:0]      i_rs_data,
  input  logic [NB_DATA-1:0]      i_rt_data,
  input  logic                    i_stall,
  input  logic                    i_flush,
  output logic                    o_valid,
  output logic [NB_OPERATION-1:0] o_op,
  output logic [NB_DATA-1:0]      o_data_a,
  output logic [NB_DATA-1:0]      o_data_b,
  output logic [NB_REG_ADDR-1:0]  o_rd_addr,
  output logic                    o_reg_write,
  output logic                    o_illegal,
  output logic [NB_ILL_CNT-1:0]   o_illegal_count
);

  localparam logic [NB_OPERATION-1:0] OP_ADD = 4'h0;
  localparam logic [NB_OPERATION-1:0] OP_SUB = 4'h1;
  localparam logic [NB_OPERATION-1:0] OP_AND = 4'h2;
  localparam logic [NB_OPERATION-1:0] OP_OR  = 4'h3;
  localparam logic [NB_OPERATION-1:0] OP_XOR = 4'h4;
  localparam logic [NB_OPERATION-1:0] OP_NOR = 4'h5;
  localparam logic [NB_OPERATION-1:0] OP_SRL = 4'h6;
  localparam logic [NB_OPERATION-1:0] OP_SLL = 4'h7;
  localparam logic [NB_OPERATION-1:0] OP_SRA = 4'h8;
  localparam logic [NB_OPERATION-1:0] OP_SLT = 4'hA;
  localparam logic [NB_OPERATION-1:0] OP_LUI = 4'hB;
  localparam logic [NB_OPERATION-1:0] OP_ILL = 4'hF;

  logic [5:0]  opcode_p0, funct_p0;
  logic [15:0] imm_p0;
  logic signed [NB_DATA-1:0] imm_sext_p0;
  logic [NB_DATA-1:0] imm_zext_p0, shamt_p0, rs_shamt_p0;

  logic [NB_OPERATION-1:0] op_p0;
  logic [NB_DATA-1:0]      a_p0, b_p0;
  logic [NB_REG_ADDR-1:0]  rd_p0;
  logic                    rw_p0, legal_p0, ill_p0;
  logic                    accept_p0;
  logic                    unused_rs_addr;

  assign opcode_p0   = i_instruction[31:26];
  assign funct_p0    = i_instruction[5:0];
  assign imm_p0      = i_instruction[15:0];
  assign imm_sext_p0 = {{(NB_DATA-16){imm_p0[15]}}, imm_p0};
  assign imm_zext_p0 = {{(NB_DATA-16){1'b0}}, imm_p0};
  assign shamt_p0    = {{(NB_DATA-5){1'b0}}, i_instruction[10:6]};
  assign rs_shamt_p0 = {{(NB_DATA-5){1'b0}}, i_rs_data[4:0]};
  assign accept_p0   = i_valid & ~i_stall & ~i_flush;
  // Operands come from read data, so the rs address field is not needed here.
  assign unused_rs_addr = ^i_instruction[25:21];

  // Stage p0: combinational decode
  always_comb begin
    op_p0    = OP_ADD;
    a_p0     = i_rs_data;
    b_p0     = i_rt_data;
    rd_p0    = i_instruction[15:11];
    rw_p0    = 1'b1;
    legal_p0 = 1'b1;
    case (opcode_p0)
      6'h00: begin
        case (funct_p0)
          6'h20, 6'h21: op_p0 = OP_ADD;
          6'h22, 6'h23: op_p0 = OP_SUB;
          6'h24:        op_p0 = OP_AND;
          6'h25:        op_p0 = OP_OR;
          6'h26:        op_p0 = OP_XOR;
          6'h27:        op_p0 = OP_NOR;
          6'h2A:        op_p0 = OP_SLT;
          6'h00: begin op_p0 = OP_SLL; a_p0 = i_rt_data; b_p0 = shamt_p0;    end
          6'h02: begin op_p0 = OP_SRL; a_p0 = i_rt_data; b_p0 = shamt_p0;    end
          6'h03: begin op_p0 = OP_SRA; a_p0 = i_rt_data; b_p0 = shamt_p0;    end
          6'h04: begin op_p0 = OP_SLL; a_p0 = i_rt_data; b_p0 = rs_shamt_p0; end
          6'h06: begin op_p0 = OP_SRL; a_p0 = i_rt_data; b_p0 = rs_shamt_p0; end
          6'h07: begin op_p0 = OP_SRA; a_p0 = i_rt_data; b_p0 = rs_shamt_p0; end
          default: legal_p0 = 1'b0;
        endcase
      end
      6'h08, 6'h09, 6'h23: begin
        op_p0 = OP_ADD; b_p0 = imm_sext_p0; rd_p0 = i_instruction[20:16];
      end
      6'h0A: begin op_p0 = OP_SLT; b_p0 = imm_sext_p0; rd_p0 = i_instruction[20:16]; end
      6'h0C: begin op_p0 = OP_AND; b_p0 = imm_zext_p0; rd_p0 = i_instruction[20:16]; end
      6'h0D: begin op_p0 = OP_OR;  b_p0 = imm_zext_p0; rd_p0 = i_instruction[20:16]; end
      6'h0E: begin op_p0 = OP_XOR; b_p0 = imm_zext_p0; rd_p0 = i_instruction[20:16]; end
      6'h0F: begin
        op_p0 = OP_LUI; a_p0 = '0; b_p0 = imm_zext_p0; rd_p0 = i_instruction[20:16];
      end
      6'h2B: begin op_p0 = OP_ADD; b_p0 = imm_sext_p0; rd_p0 = '0; rw_p0 = 1'b0; end
      6'h04, 6'h05: begin op_p0 = OP_SUB; rd_p0 = '0; rw_p0 = 1'b0; end
      default: legal_p0 = 1'b0;
    endcase
    if (!legal_p0) begin
      op_p0 = OP_ILL;
      a_p0  = '0;
      b_p0  = '0;
      rd_p0 = '0;
      rw_p0 = 1'b0;
    end
    ill_p0 = ~legal_p0;
  end

  // Stage p1: output registers (flush > stall > load)
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      o_valid     <= 1'b0;
      o_op        <= OP_ADD;
      o_data_a    <= '0;
      o_data_b    <= '0;
      o_rd_addr   <= '0;
      o_reg_write <= 1'b0;
      o_illegal   <= 1'b0;
    end else if (i_flush) begin
      o_valid     <= 1'b0;
      o_reg_write <= 1'b0;
      o_illegal   <= 1'b0;
    end else if (!i_stall) begin
      o_valid     <= i_valid;
      o_op        <= op_p0;
      o_data_a    <= a_p0;
      o_data_b    <= b_p0;
      o_rd_addr   <= rd_p0;
      o_reg_write <= rw_p0 & i_valid;
      o_illegal   <= ill_p0 & i_valid;
    end
  end

`ifdef ALU_OP_ISSUE_ILLEGAL_CNT_EN
  function automatic logic [NB_ILL_CNT-1:0] sat_inc(input logic [NB_ILL_CNT-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  logic [NB_ILL_CNT-1:0] ill_cnt_p1;

  always_ff @(posedge i_clock) begin
    if (i_reset)
      ill_cnt_p1 <= '0;
    else if (accept_p0 && ill_p0)
      ill_cnt_p1 <= sat_inc(ill_cnt_p1);
  end

  assign o_illegal_count = ill_cnt_p1;
`else
  logic unused_accept;
  assign unused_accept   = accept_p0;
  assign o_illegal_count = '0;
`endif

endmodule

// File: tb/tb_alu_op_issue.sv
// Directed bench for alu_op_issue: decode vector table plus stall/flush/reset/illegal sequences.
module tb_alu_op_issue;
  logic        clk = 1'b0;
  logic        rst, valid, stall, flush;
  logic [31:0] instr, rs, rt;
  logic        o_valid, o_reg_write, o_illegal;
  logic [3:0]  o_op;
  logic [31:0] o_a, o_b;
  logic [4:0]  o_rd;
  logic [7:0]  o_cnt;

  int total = 0;
  int bad   = 0;
  int exp_cnt = 0;

  always #5 clk = ~clk;

  alu_op_issue dut (
    .i_clock(clk), .i_reset(rst), .i_valid(valid), .i_instruction(instr),
    .i_rs_data(rs), .i_rt_data(rt), .i_stall(stall), .i_flush(flush),
    .o_valid(o_valid), .o_op(o_op), .o_data_a(o_a), .o_data_b(o_b),
    .o_rd_addr(o_rd), .o_reg_write(o_reg_write), .o_illegal(o_illegal),
    .o_illegal_count(o_cnt)
  );

  typedef struct {
    logic [31:0] instr, rs, rt;
    logic [3:0]  op;
    logic [31:0] a, b;
    logic [4:0]  rd;
    logic        rw, ill;
  } vec_t;

  vec_t vecs [13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] i, input logic [31:0] a,
                       input logic [31:0] b, input logic s, input logic f, input logic r);
    @(negedge clk);
    valid = v; instr = i; rs = a; rt = b; stall = s; flush = f; rst = r;
    @(posedge clk);
    #1;
  endtask

  function automatic int exp_count(input int n);
`ifdef ALU_OP_ISSUE_ILLEGAL_CNT_EN
    return (n > 255) ? 255 : n;
`else
    return 0 * n;
`endif
  endfunction

  task automatic check_all(input string tag, input logic v, input logic [3:0] op,
                           input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd,
                           input logic rw, input logic ill);
    check({tag, ".valid"}, 32'(o_valid), 32'(v));
    check({tag, ".op"}, 32'(o_op), 32'(op));
    check({tag, ".a"}, o_a, a);
    check({tag, ".b"}, o_b, b);
    check({tag, ".rd"}, 32'(o_rd), 32'(rd));
    check({tag, ".reg_write"}, 32'(o_reg_write), 32'(rw));
    check({tag, ".illegal"}, 32'(o_illegal), 32'(ill));
    check({tag, ".count"}, 32'(o_cnt), 32'(exp_count(exp_cnt)));
  endtask

  initial begin
    vecs[0]  = '{32'h01095020, 32'd5,        32'd7,        4'h0, 32'd5,        32'd7,        5'd10, 1'b1, 1'b0};
    vecs[1]  = '{32'h00094080, 32'h11,       32'h3,        4'h7, 32'h3,        32'd2,        5'd8,  1'b1, 1'b0};
    vecs[2]  = '{32'h3C01ABCD, 32'h1234,     32'h55,       4'hB, 32'h0,        32'h0000ABCD, 5'd1,  1'b1, 1'b0};
    vecs[3]  = '{32'h2108FFFF, 32'd10,       32'h99,       4'h0, 32'd10,       32'hFFFFFFFF, 5'd8,  1'b1, 1'b0};
    vecs[4]  = '{32'h01095022, 32'd20,       32'd3,        4'h1, 32'd20,       32'd3,        5'd10, 1'b1, 1'b0};
    vecs[5]  = '{32'h01095007, 32'h25,       32'h80000000, 4'h8, 32'h80000000, 32'd5,        5'd10, 1'b1, 1'b0};
    vecs[6]  = '{32'hAD09FFF0, 32'h1000,     32'h77,       4'h0, 32'h1000,     32'hFFFFFFF0, 5'd0,  1'b0, 1'b0};
    vecs[7]  = '{32'h11090004, 32'hA,        32'hB,        4'h1, 32'hA,        32'hB,        5'd0,  1'b0, 1'b0};
    vecs[8]  = '{32'h3508F0F0, 32'h0F,       32'h1,        4'h3, 32'h0F,       32'h0000F0F0, 5'd8,  1'b1, 1'b0};
    vecs[9]  = '{32'h2908FFFE, 32'h3,        32'h1,        4'hA, 32'h3,        32'hFFFFFFFE, 5'd8,  1'b1, 1'b0};
    vecs[10] = '{32'h01095027, 32'hF0,       32'h0F,       4'h5, 32'hF0,       32'h0F,       5'd10, 1'b1, 1'b0};
    vecs[11] = '{32'h01095001, 32'h1,        32'h2,        4'hF, 32'h0,        32'h0,        5'd0,  1'b0, 1'b1};
    vecs[12] = '{32'hFC000000, 32'h3,        32'h4,        4'hF, 32'h0,        32'h0,        5'd0,  1'b0, 1'b1};

    // reset with arbitrary inputs
    drive(1'b1, 32'h01095020, 32'hDEAD, 32'hBEEF, 1'b0, 1'b0, 1'b1);
    drive(1'b1, 32'hFC000000, 32'hDEAD, 32'hBEEF, 1'b0, 1'b0, 1'b1);
    check_all("reset", 1'b0, 4'h0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0);

    foreach (vecs[i]) begin
      drive(1'b1, vecs[i].instr, vecs[i].rs, vecs[i].rt, 1'b0, 1'b0, 1'b0);
      if (vecs[i].ill) exp_cnt++;
      check_all($sformatf("vec%0d", i), 1'b1, vecs[i].op, vecs[i].a, vecs[i].b,
                vecs[i].rd, vecs[i].rw, vecs[i].ill);
    end

    // bubble: valid low loads no write and no illegal flag
    drive(1'b0, 32'hFC000000, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    check("bubble.valid", 32'(o_valid), 32'd0);
    check("bubble.reg_write", 32'(o_reg_write), 32'd0);
    check("bubble.illegal", 32'(o_illegal), 32'd0);
    check("bubble.count", 32'(o_cnt), 32'(exp_count(exp_cnt)));

    // ADD then stall for three cycles while presenting SUB
    drive(1'b1, 32'h01095020, 32'd5, 32'd7, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 32'h01095022, 32'd20, 32'd3, 1'b1, 1'b0, 1'b0);
      check_all($sformatf("stall%0d", k), 1'b1, 4'h0, 32'd5, 32'd7, 5'd10, 1'b1, 1'b0);
    end
    // flush wins over stall and SUB is not loaded
    drive(1'b1, 32'h01095022, 32'd20, 32'd3, 1'b1, 1'b1, 1'b0);
    check("flush.valid", 32'(o_valid), 32'd0);
    check("flush.reg_write", 32'(o_reg_write), 32'd0);
    check("flush.op_kept", 32'(o_op), 32'h0);
    drive(1'b1, 32'h01095022, 32'd20, 32'd3, 1'b0, 1'b0, 1'b0);
    check_all("release", 1'b1, 4'h1, 32'd20, 32'd3, 5'd10, 1'b1, 1'b0);

    // stall over an illegal instruction adds no count
    drive(1'b1, 32'hFC000000, 32'd1, 32'd1, 1'b0, 1'b0, 1'b0);
    exp_cnt++;
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 32'hFC000000, 32'd1, 32'd1, 1'b1, 1'b0, 1'b0);
      check_all($sformatf("ill_stall%0d", k), 1'b1, 4'hF, 32'h0, 32'h0, 5'd0, 1'b0, 1'b1);
    end
    // flushed illegal is not accepted either
    drive(1'b1, 32'hFC000000, 32'd1, 32'd1, 1'b0, 1'b1, 1'b0);
    check("ill_flush.illegal", 32'(o_illegal), 32'd0);
    check("ill_flush.count", 32'(o_cnt), 32'(exp_count(exp_cnt)));

    // reset mid-stall clears everything
    drive(1'b1, 32'h01095020, 32'd5, 32'd7, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 32'h01095020, 32'd5, 32'd7, 1'b1, 1'b0, 1'b1);
    exp_cnt = 0;
    check_all("rst_stall", 1'b0, 4'h0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0);

    // 300 illegal instructions: saturating count
    for (int k = 0; k < 300; k++) begin
      drive(1'b1, 32'hFC000000, 32'h5, 32'h6, 1'b0, 1'b0, 1'b0);
      exp_cnt++;
      check($sformatf("ill%0d.op", k), 32'(o_op), 32'hF);
      check($sformatf("ill%0d.illegal", k), 32'(o_illegal), 32'd1);
      check($sformatf("ill%0d.reg_write", k), 32'(o_reg_write), 32'd0);
      check($sformatf("ill%0d.count", k), 32'(o_cnt), 32'(exp_count(exp_cnt)));
    end
`ifdef ALU_OP_ISSUE_ILLEGAL_CNT_EN
    check("ill_final_count", 32'(o_cnt), 32'd255);
`else
    check("ill_final_count", 32'(o_cnt), 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/alu_op_issue.md
# alu_op_issue

- Registered issue stage that feeds the 32-bit MIPS ALU: decodes a raw instruction plus register-file read data into the ALU's 4-bit operation code and its A/B operands.
- Also produces destination-register information for writeback.
- Sits at the ID/EX boundary and supplies the ALU's `i_op`, `i_data_a` and `i_data_b` one cycle after issue.
- Supports stall (hold) and flush (bubble) from hazard control.

## Interface
Parameters:
- `NB_DATA`, 32, operand/data width.
- `NB_OPERATION`, 4, ALU operation code width.
- `NB_REG_ADDR`, 5, register address width.
- `NB_ILL_CNT`, 8, illegal-instruction counter width.

Ports:
- `i_clock`  in  1  single clock; all state updates on rising edge.
- `i_reset`  in  1  synchronous, active-high reset.
- `i_valid`  in  1  instruction/operands valid this cycle.
- `i_instruction`  in  32  MIPS instruction word.
- `i_rs_data`  in  NB_DATA  register file read data for rs.
- `i_rt_data`  in  NB_DATA  register file read data for rt.
- `i_stall`  in  1  hold all output registers.
- `i_flush`  in  1  squash the output stage.
- `o_valid`  out  1  registered outputs hold a valid instruction.
- `o_op`  out  NB_OPERATION  ALU operation code.
- `o_data_a`  out  NB_DATA  ALU operand A.
- `o_data_b`  out  NB_DATA  ALU operand B.
- `o_rd_addr`  out  NB_REG_ADDR  writeback destination.
- `o_reg_write`  out  1  writeback enable.
- `o_illegal`  out  1  current output instruction not decodable.
- `o_illegal_count`  out  NB_ILL_CNT  saturating illegal-instruction count.

## Operation
Operation codes:
- ADD=0, SUB=1, AND=2, OR=3, XOR=4, NOR=5, SRL=6, SLL=7, SRA=8, SLA=9, SLT=A, LUI=B, illegal=F.

R-type (opcode 0x00):
- A=rs, B=rt, rd=instr[15:11], reg_write=1.
- funct 20/21→ADD, 22/23→SUB, 24→AND, 25→OR, 26→XOR, 27→NOR, 2A→SLT.
- Immediate shifts: funct 00→SLL, 02→SRL, 03→SRA, with A=rt and B=zero-extended shamt instr[10:6].
- Variable shifts: funct 04→SLL, 06→SRL, 07→SRA, with A=rt and B=zero-extended rs[4:0].

I-type (rd=instr[20:16], reg_write=1):
- Sign-extended immediate, A=rs: 08/09→ADD, 0A→SLT, 23 (LW)→ADD.
- Zero-extended immediate, A=rs: 0C→AND, 0D→OR, 0E→XOR.
- 0F→LUI, with A=0 and B=zero-extended imm.
- 2B (SW)→ADD with sign-extended imm; reg_write=0, rd=0.
- 04/05 (BEQ/BNE)→SUB with A=rs, B=rt; reg_write=0, rd=0.

Illegal instructions:
- Any other opcode or funct gives op=F, A=B=0, rd=0, reg_write=0, o_illegal=1.

Accept rule:
- An instruction is accepted when `i_valid & ~i_stall & ~i_flush`.

## Timing
- Reset: all outputs 0, including `o_valid`, `o_op` (=ADD), `o_illegal` and `o_illegal_count`.
- Latency is 1 cycle: an instruction accepted at edge N appears on the outputs after edge N.

Per-edge priority:
1. reset
2. flush: `o_valid`, `o_reg_write` and `o_illegal` go to 0; other outputs may be left unchanged.
3. stall: every output holds, including `o_valid`.
4. otherwise: load the decode, with `o_valid=i_valid`.

Boundary cases:
- `i_valid=0` without stall loads a bubble: `o_valid=0`, `o_reg_write=0`, `o_illegal=0`.
- Flush and stall asserted together: flush wins.
- The input is dropped; upstream must re-present it.
- Stall over an illegal instruction: no extra count.
- Reset asserted mid-stall clears everything on the next edge.
- Sign extension replicates instr[15]; zero extension fills with 0.

## Configuration
With `ALU_OP_ISSUE_ILLEGAL_CNT_EN` defined:
- `o_illegal_count` increments by 1 on each accepted illegal instruction.
- It saturates at 2^NB_ILL_CNT-1 and clears only on reset.

Without the macro:
- `o_illegal_count` is constant 0 and no counter register is synthesized.
- `o_illegal` is unaffected in both builds.

## Test plan
- Reset: hold `i_reset` for 2 cycles with arbitrary inputs → all outputs 0; `o_valid`=0.
- R-type ADD: instr 0x01095020 (add $10,$8,$9), rs=5, rt=7, valid → next cycle `o_op`=0, A=5, B=7, rd=10, `o_reg_write`=1, `o_valid`=1.
- Shift and LUI: instr 0x00094080 (sll $8,$9,2) with rt=0x3 → op=7, A=3, B=2. Then instr 0x3C01ABCD (lui) → op=B, A=0, B=0x0000ABCD, rd=1.
- Sign extension: instr 0x2108FFFF (addi $8,$8,-1) with rs=10 → op=0, A=10, B=0xFFFFFFFF, rd=8.
- Stall/flush:
  - Issue ADD, then stall 3 cycles while presenting SUB → outputs frozen on ADD.
  - Stall+flush together → `o_valid`=0, and SUB is not loaded.
  - Release → SUB appears after 1 cycle.
- Illegal: instr 0xFC000000, valid, 300 times →
  - `o_op`=F, `o_illegal`=1, `o_reg_write`=0 each time.
  - With macro, `o_illegal_count` ends at 255.
  - Without macro, the count stays 0.
